// File: rtl/l2_request_arbiter.sv
// Round-robin arbiter sharing the L2 port between I-cache and D-cache miss paths,
// with per-requester grant and stall statistics.
module l2_request_arbiter #(
  parameter int ADDR_W = 26,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  output logic              d_done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_src,
  input  logic              mem_ack,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants,
  output logic [CNT_W-1:0]  i_stalls,
  output logic [CNT_W-1:0]  d_stalls
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   last;

  logic grant_i, grant_d;
  logic own_i, own_d;
  logic stall_i, stall_d;
  logic fin_i, fin_d;

  // last = 1 means D was granted most recently, so a tie goes to I
  assign grant_d = (state == IDLE) && d_req && (!i_req || !last);
  assign grant_i = (state == IDLE) && i_req && !grant_d;
  assign own_i   = (state != IDLE) && !mem_src;
  assign own_d   = (state != IDLE) && mem_src;
  assign stall_i = i_req && !grant_i && !own_i;
  assign stall_d = d_req && !grant_d && !own_d;
  assign fin_i   = (state == BUSY) && mem_ack && !mem_src;
  assign fin_d   = (state == BUSY) && mem_ack && mem_src;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      mem_src  <= 1'b0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_addr <= d_addr;
            mem_we   <= d_we;
            mem_src  <= 1'b1;
            mem_req  <= 1'b1;
            last     <= 1'b1;
            state    <= BUSY;
          end else if (grant_i) begin
            mem_addr <= i_addr;
            mem_we   <= 1'b0;
            mem_src  <= 1'b0;
            mem_req  <= 1'b1;
            last     <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            i_done  <= !mem_src;
            d_done  <= mem_src;
            state   <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_grants <= '0;
      d_grants <= '0;
      i_stalls <= '0;
      d_stalls <= '0;
    end else if (clr_stats) begin
      i_grants <= '0;
      d_grants <= '0;
      i_stalls <= '0;
      d_stalls <= '0;
    end else begin
      if (fin_i)   i_grants <= sat_inc(i_grants);
      if (fin_d)   d_grants <= sat_inc(d_grants);
      if (stall_i) i_stalls <= sat_inc(i_stalls);
      if (stall_d) d_stalls <= sat_inc(d_stalls);
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: per-cycle vector table plus hand-written
// sequences for alternation, long ack wait, mid-transaction reset and stats clear.
module tb_l2_request_arbiter;
  localparam int ADDR_W = 26;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
  logic              mem_ack = 1'b0, clr_stats = 1'b0;
  logic              i_done, d_done, mem_req, mem_we, mem_src;
  logic [ADDR_W-1:0] mem_addr;
  logic [CNT_W-1:0]  i_grants, d_grants, i_stalls, d_stalls;

  int checks = 0;
  int errors = 0;

  l2_request_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_done(d_done),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_src(mem_src),
    .mem_ack(mem_ack), .clr_stats(clr_stats),
    .i_grants(i_grants), .d_grants(d_grants), .i_stalls(i_stalls), .d_stalls(d_stalls)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic              ack;
    logic              e_req;
    logic [ADDR_W-1:0] e_addr;
    logic              e_src;
    logic              e_we;
    logic              e_idone;
    logic              e_ddone;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0; clr_stats = 1'b0;
    i_addr = '0; d_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic add(input logic r, input logic ir, input logic [ADDR_W-1:0] ia,
                     input logic dr, input logic [ADDR_W-1:0] da, input logic dw,
                     input logic ak, input logic er, input logic [ADDR_W-1:0] ea,
                     input logic es, input logic ew, input logic eid, input logic edd);
    vec_t v;
    v = '{r, ir, ia, dr, da, dw, ak, er, ea, es, ew, eid, edd};
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int n = lo; n <= hi; n++) begin
      rst = vecs[n].rst;
      i_req = vecs[n].i_req; i_addr = vecs[n].i_addr;
      d_req = vecs[n].d_req; d_addr = vecs[n].d_addr; d_we = vecs[n].d_we;
      mem_ack = vecs[n].ack;
      step();
      chk($sformatf("vec%0d", n),
          {33'd0, mem_req, mem_addr, mem_src, mem_we, i_done, d_done},
          {33'd0, vecs[n].e_req, vecs[n].e_addr, vecs[n].e_src, vecs[n].e_we,
           vecs[n].e_idone, vecs[n].e_ddone});
    end
  endtask

  logic              stable;
  logic [ADDR_W-1:0] held_addr;
  logic              done_seen;

  initial begin
    // rst  ireq iaddr        dreq daddr        dwe ack | req addr         src we idn ddn
    add(1, 0, 26'h0,       0, 26'h0,       0, 0,   0, 26'h0,       0, 0, 0, 0);
    add(0, 1, 26'h00ABCDE, 0, 26'h0,       0, 1,   1, 26'h00ABCDE, 0, 0, 0, 0);
    add(0, 1, 26'h00ABCDE, 0, 26'h0,       0, 1,   0, 26'h00ABCDE, 0, 0, 1, 0);
    add(0, 0, 26'h0,       0, 26'h0,       0, 1,   0, 26'h00ABCDE, 0, 0, 0, 0);
    add(0, 0, 26'h0,       0, 26'h0,       0, 1,   0, 26'h00ABCDE, 0, 0, 0, 0);
    add(1, 0, 26'h0,       0, 26'h0,       0, 0,   0, 26'h0,       0, 0, 0, 0);
    add(0, 1, 26'h0000111, 1, 26'h3FFFFFF, 1, 1,   1, 26'h0000111, 0, 0, 0, 0);
    add(0, 1, 26'h0000111, 1, 26'h3FFFFFF, 1, 1,   0, 26'h0000111, 0, 0, 1, 0);
    add(0, 0, 26'h0,       1, 26'h3FFFFFF, 1, 1,   0, 26'h0000111, 0, 0, 0, 0);
    add(0, 0, 26'h0,       1, 26'h3FFFFFF, 1, 1,   1, 26'h3FFFFFF, 1, 1, 0, 0);
    add(0, 0, 26'h0,       1, 26'h3FFFFFF, 1, 1,   0, 26'h3FFFFFF, 1, 1, 0, 1);
    add(0, 0, 26'h0,       0, 26'h0,       0, 1,   0, 26'h3FFFFFF, 1, 1, 0, 0);

    idle_inputs();
    #2;
    chk("reset_outputs", {mem_req, mem_we, mem_src, i_done, d_done, mem_addr}, 0);
    chk("reset_counters", {i_grants, d_grants} | {i_stalls, d_stalls}, 0);

    // Single I request with immediate ack
    run_vecs(0, 4);
    chk("a_i_grants", i_grants, 1);
    chk("a_i_stalls", i_stalls, 0);

    // Simultaneous requests from reset: I first, then D
    run_vecs(5, 11);
    chk("b_d_stalls", d_stalls, 3);
    chk("b_i_grants", i_grants, 1);
    chk("b_d_grants", d_grants, 1);
    chk("b_i_stalls", i_stalls, 0);

    // Both held continuously: strict alternation
    do_reset();
    i_req = 1; i_addr = 26'h0000AAA; d_req = 1; d_addr = 26'h0000DDD; mem_ack = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("alt_grant%0d", k), {mem_req, mem_src}, {1'b1, 1'(k % 2)});
      step();
      step();
    end
    idle_inputs();
    chk("alt_i_grants", i_grants, 3);
    chk("alt_d_grants", d_grants, 3);
    step();

    // Long ack wait: outputs hold, waiting requester stalls
    do_reset();
    d_req = 1; d_addr = 26'h1234567; d_we = 0; mem_ack = 0;
    step();
    chk("wait_grant", {mem_req, mem_src, mem_addr}, {1'b1, 1'b1, 26'h1234567});
    i_req = 1; i_addr = 26'h0000042; d_we = 1;
    stable = 1'b1;
    held_addr = mem_addr;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!mem_req || !mem_src || mem_we || mem_addr != held_addr || d_done || i_done)
        stable = 1'b0;
    end
    chk("wait_stable", stable, 1);
    chk("wait_i_stalls", i_stalls, 10);
    mem_ack = 1;
    step();
    chk("wait_done", {mem_req, d_done, i_done}, 3'b010);
    idle_inputs();
    step();
    step();

    // Reset in BUSY abandons the transaction
    do_reset();
    i_req = 1; i_addr = 26'h2AAAAAA; mem_ack = 0;
    step();
    chk("rst_busy_req", mem_req, 1);
    step();
    rst = 1;
    #1;
    chk("rst_async_drop", {mem_req, i_done, d_done}, 3'b000);
    i_req = 0; mem_ack = 1;
    step();
    rst = 0;
    done_seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (i_done || d_done || mem_req) done_seen = 1'b1;
    end
    chk("rst_no_done", done_seen, 0);
    i_req = 1; i_addr = 26'h00ABCDE;
    step();
    chk("rst_regrant", {mem_req, mem_src, mem_we, mem_addr}, {3'b100, 26'h00ABCDE});
    step();
    chk("rst_regrant_done", {mem_req, i_done}, 2'b01);
    i_req = 0;
    step();

    // clr_stats on the completing ack edge
    do_reset();
    i_req = 1; i_addr = 26'h0000777; d_req = 1; d_addr = 26'h0000888; mem_ack = 1;
    step();
    chk("clr_pre_d_stalls", d_stalls, 1);
    clr_stats = 1;
    step();
    clr_stats = 0;
    chk("clr_done_pulse", {mem_req, i_done}, 2'b01);
    chk("clr_counters", {i_grants, d_grants} | {i_stalls, d_stalls}, 0);
    i_req = 0;
    step();
    chk("clr_fsm_intact", {d_stalls[3:0], mem_req, i_done}, {4'd1, 2'b00});
    step();
    chk("clr_next_grant", {mem_req, mem_src}, 2'b11);
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

Shares the single next-level (L2) memory port between the instruction-cache and data-cache miss paths. Each cache raises a line-fill or write-back request carrying a 26-bit line address (`addr[31:6]`). The arbiter grants one requester at a time with round-robin fairness and holds that transaction until the L2 acknowledges it. It also keeps per-requester grant and stall counters for the statistics module.

## Interface
- `ADDR_W`, 26: line-address width (byte address bits [31:6]).
- `CNT_W`, 32: statistics counter width.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  instruction-cache request; held high until `i_done`.
- `i_addr`  in  ADDR_W  instruction-cache line address; stable while `i_req` is high.
- `i_done`  out  1  one-cycle pulse when the instruction transaction completes.
- `d_req`  in  1  data-cache request; held high until `d_done`.
- `d_addr`  in  ADDR_W  data-cache line address.
- `d_we`  in  1  data request type: 1 = write-back, 0 = fill.
- `d_done`  out  1  one-cycle completion pulse for the data cache.
- `mem_req`  out  1  request to L2.
- `mem_addr`  out  ADDR_W  latched line address.
- `mem_we`  out  1  latched write flag; always 0 for instruction requests.
- `mem_src`  out  1  owner of the current transaction: 0 = I, 1 = D.
- `mem_ack`  in  1  L2 acceptance; sampled only in BUSY.
- `clr_stats`  in  1  synchronous clear of all counters (trace command 8).
- `i_grants`, `d_grants`  out  CNT_W  transactions completed per requester.
- `i_stalls`, `d_stalls`  out  CNT_W  cycles each requester waited.

## Operation
- FSM states: IDLE, BUSY, DONE.
- `last` register: source of the most recent grant.

IDLE:
- Only one request high: grant it.
- Both high: grant the source opposite `last`.
- On grant: latch `mem_addr`, `mem_we` (`d_we` for D, 0 for I) and `mem_src`; set `mem_req` = 1; update `last`; go to BUSY.
- Neither high: stay in IDLE.

BUSY:
- Hold `mem_req`, `mem_addr`, `mem_we` and `mem_src` constant.
- Ignore `i_req`, `d_req` and `d_we`.
- On an edge with `mem_ack` = 1: clear `mem_req`, pulse the owner's done, increment the owner's grant counter, go to DONE.
- No timeout; BUSY waits indefinitely for `mem_ack`.

DONE:
- Lasts exactly one cycle; the requester drops its request during it.
- Requests are not sampled; `mem_ack` is ignored.
- Clear the done pulse and go to IDLE.

Stall counters:
- A requester's stall counter increments on every edge where its request is high and it is neither granted at that edge nor the owner in BUSY or DONE.
- Counters saturate at all-ones.
- `clr_stats` zeroes all four counters, wins over a same-edge increment, and does not disturb the FSM.

## Timing
- Reset values: state IDLE, `last` = 1 (first tie goes to I), `mem_req` = 0, `mem_addr` = 0, `mem_we` = 0, `mem_src` = 0, `i_done` = `d_done` = 0, all counters 0.
- All outputs are registered; no combinational path from input to output.
- Request sampled high in IDLE at edge E0: `mem_req` is high after E0.
- `mem_ack` sampled high at edge Ek: done is high and `mem_req` low for the cycle after Ek; state returns to IDLE after Ek+1.
- The earliest next grant is at Ek+2.
- With an immediate ack, back-to-back grants are spaced 3 cycles apart.
- `rst` asserted mid-transaction: `mem_req` and done drop immediately; the transaction is abandoned; there is no replay.
- `mem_ack` high while in IDLE or DONE has no effect.

## Test plan
- Reset, then `i_req` = 1 with `i_addr` = 0x00ABCDE and `mem_ack` tied high: `mem_req` rises 1 cycle later with `mem_addr` = 0x00ABCDE, `mem_src` = 0, `mem_we` = 0. `i_done` pulses the next cycle. `i_grants` = 1, `i_stalls` = 0.
- `i_req` and `d_req` asserted together from reset, each held until its done, ack immediate: the I transaction is granted first, then D. `d_stalls` = 3 and `mem_we` follows `d_we`.
- Both requests asserted continuously for 6 transactions: grants strictly alternate I, D, I, D, I, D; `i_grants` = `d_grants` = 3.
- `mem_ack` held low for 10 cycles in BUSY: `mem_req`, `mem_addr` and `mem_src` stay constant; the other requester's stall counter grows by 10.
- `rst` pulsed while BUSY: `mem_req` = 0 and no done pulse is produced. A new request after reset follows the first-scenario timing.
- `clr_stats` asserted on the same edge as a completing ack: all counters read 0 afterwards and the done pulse still occurs.
